// File: rtl/board_b_pkg.sv
// Shared types and sizes for the B-board background tile ROM path.
package board_b_pkg;

   localparam int NUM_BG_LAYERS = 3;
   localparam int BG_ROM_AW     = 21;
   localparam int SDR_AW        = 25;

   typedef logic [1:0] layer_id_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } arb_state_t;

   function automatic layer_id_t next_layer(input layer_id_t i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

endpackage

// File: rtl/board_b_rom_arbiter_rr_pick3.sv
// Combinational round-robin picker: first pending layer at or after ptr.
module rr_pick3
   import board_b_pkg::*;
(
   input  logic [2:0] pend,
   input  layer_id_t  ptr,
   output logic       valid,
   output layer_id_t  gnt
);

   always_comb begin
      valid = |pend;
      gnt   = 2'd0;
      case (ptr)
         2'd1: begin
            if (pend[1])      gnt = 2'd1;
            else if (pend[2]) gnt = 2'd2;
            else              gnt = 2'd0;
         end
         2'd2: begin
            if (pend[2])      gnt = 2'd2;
            else if (pend[0]) gnt = 2'd0;
            else              gnt = 2'd1;
         end
         default: begin
            if (pend[0])      gnt = 2'd0;
            else if (pend[1]) gnt = 2'd1;
            else              gnt = 2'd2;
         end
      endcase
   end

endmodule

// File: rtl/board_b_rom_arbiter.sv
// Round-robin share of one SDRAM read port among three BG tile fetchers.
// Optional ROM_ARB_LAST_HIT_EN: per-layer last-word cache answers repeats.
module board_b_rom_arbiter
   import board_b_pkg::*;
#(
   parameter int NUM_LAYERS = 3,
   parameter int LAYER_AW   = 21,
   parameter int SDR_AW     = 25,
   parameter logic [SDR_AW-1:0] ROM_BASE = '0
) (
   input  logic                           CLK_32M,
   input  logic                           reset,
   input  logic [NUM_LAYERS-1:0]          l_req,
   input  logic [NUM_LAYERS*LAYER_AW-1:0] l_addr,
   output logic [31:0]                    l_data,
   output logic [NUM_LAYERS-1:0]          l_rdy,
   output logic [SDR_AW-1:0]              sdr_addr,
   output logic                           sdr_req,
   input  logic [31:0]                    sdr_data,
   input  logic                           sdr_rdy
);

   arb_state_t state_q, state_d;
   layer_id_t  ptr_q, ptr_d;
   layer_id_t  gnt_q, gnt_d;
   logic [NUM_LAYERS-1:0] pend_q, pend_d;
   logic [NUM_LAYERS-1:0] l_rdy_q, l_rdy_d;
   logic [NUM_LAYERS-1:0][LAYER_AW-1:0] addr_q, addr_d;
   logic              sdr_req_q, sdr_req_d;
   logic [SDR_AW-1:0] sdr_addr_q, sdr_addr_d;
   logic [31:0]       l_data_q, l_data_d;
   logic              pick_vld;
   layer_id_t         pick_gnt;

`ifdef ROM_ARB_LAST_HIT_EN
   logic [NUM_LAYERS-1:0] last_vld_q, last_vld_d;
   logic [NUM_LAYERS-1:0] hit_q, hit_d;
   logic [NUM_LAYERS-1:0][LAYER_AW-1:0] last_addr_q, last_addr_d;
   logic [NUM_LAYERS-1:0][31:0] last_data_q, last_data_d;
   layer_id_t hit_sel;
`endif

   rr_pick3 u_pick (
      .pend  (pend_q),
      .ptr   (ptr_q),
      .valid (pick_vld),
      .gnt   (pick_gnt)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      pend_d     = pend_q;
      addr_d     = addr_q;
      sdr_req_d  = sdr_req_q;
      sdr_addr_d = sdr_addr_q;
      l_data_d   = l_data_q;
      l_rdy_d    = '0;
`ifdef ROM_ARB_LAST_HIT_EN
      last_vld_d  = last_vld_q;
      last_addr_d = last_addr_q;
      last_data_d = last_data_q;
      hit_d       = hit_q;
      hit_sel     = 2'd0;
`endif
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_vld) begin
               sdr_req_d  = 1'b1;
               sdr_addr_d = ROM_BASE + SDR_AW'(addr_q[pick_gnt]);
               pend_d[pick_gnt] = 1'b0;
               ptr_d      = next_layer(pick_gnt);
               gnt_d      = pick_gnt;
               state_d    = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (sdr_rdy) begin
               l_data_d       = sdr_data;
               l_rdy_d[gnt_q] = 1'b1;
               sdr_req_d      = 1'b0;
               state_d        = ARB_IDLE;
`ifdef ROM_ARB_LAST_HIT_EN
               last_vld_d[gnt_q]  = 1'b1;
               last_addr_d[gnt_q] = LAYER_AW'(sdr_addr_q - ROM_BASE);
               last_data_d[gnt_q] = sdr_data;
`endif
            end
         end
      endcase
`ifdef ROM_ARB_LAST_HIT_EN
      // A completion owns the shared ready bus; waiting hits go next edge.
      for (int i = NUM_LAYERS - 1; i >= 0; i--)
         if (hit_q[i]) hit_sel = layer_id_t'(i);
      if (hit_q != '0 && l_rdy_d == '0) begin
         l_rdy_d[hit_sel] = 1'b1;
         l_data_d         = last_data_q[hit_sel];
         hit_d[hit_sel]   = 1'b0;
      end
`endif
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (l_req[i]) begin
`ifdef ROM_ARB_LAST_HIT_EN
            if (last_vld_q[i] &&
                l_addr[i*LAYER_AW +: LAYER_AW] == last_addr_q[i]) begin
               hit_d[i] = 1'b1;
            end else begin
               pend_d[i] = 1'b1;
               addr_d[i] = l_addr[i*LAYER_AW +: LAYER_AW];
            end
`else
            pend_d[i] = 1'b1;
            addr_d[i] = l_addr[i*LAYER_AW +: LAYER_AW];
`endif
         end
      end
   end

   always_ff @(posedge CLK_32M) begin
      if (reset) begin
         state_q    <= ARB_IDLE;
         ptr_q      <= 2'd0;
         gnt_q      <= 2'd0;
         pend_q     <= '0;
         addr_q     <= '0;
         sdr_req_q  <= 1'b0;
         sdr_addr_q <= '0;
         l_data_q   <= '0;
         l_rdy_q    <= '0;
`ifdef ROM_ARB_LAST_HIT_EN
         last_vld_q  <= '0;
         last_addr_q <= '0;
         last_data_q <= '0;
         hit_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         pend_q     <= pend_d;
         addr_q     <= addr_d;
         sdr_req_q  <= sdr_req_d;
         sdr_addr_q <= sdr_addr_d;
         l_data_q   <= l_data_d;
         l_rdy_q    <= l_rdy_d;
`ifdef ROM_ARB_LAST_HIT_EN
         last_vld_q  <= last_vld_d;
         last_addr_q <= last_addr_d;
         last_data_q <= last_data_d;
         hit_q       <= hit_d;
`endif
      end
   end

   assign sdr_req  = sdr_req_q;
   assign sdr_addr = sdr_addr_q;
   assign l_data   = l_data_q;
   assign l_rdy    = l_rdy_q;

endmodule

// File: tb/tb_board_b_rom_arbiter.sv
// Directed + random bench for board_b_rom_arbiter against a queue-level model.
module tb_board_b_rom_arbiter;

   localparam logic [24:0] BASE = 25'h100000;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  l_req;
   logic [62:0] l_addr;
   logic [31:0] l_data;
   logic [2:0]  l_rdy;
   logic [24:0] sdr_addr;
   logic        sdr_req;
   logic [31:0] sdr_data;
   logic        sdr_rdy;

   board_b_rom_arbiter #(
      .NUM_LAYERS (3),
      .LAYER_AW   (21),
      .SDR_AW     (25),
      .ROM_BASE   (BASE)
   ) dut (
      .CLK_32M  (clk),
      .reset    (reset),
      .l_req    (l_req),
      .l_addr   (l_addr),
      .l_data   (l_data),
      .l_rdy    (l_rdy),
      .sdr_addr (sdr_addr),
      .sdr_req  (sdr_req),
      .sdr_data (sdr_data),
      .sdr_rdy  (sdr_rdy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: set of pending layers with newest address, one outstanding read.
   logic [2:0]       m_pend;
   logic [20:0]      m_addr [3];
   int               m_ptr;
   int               m_out;
   logic [20:0]      m_out_la;
   logic [31:0]      m_ldata;
   logic [2:0]       m_lv;
   logic [20:0]      m_la [3];
   logic [31:0]      m_ld [3];
   logic [2:0]       m_hit;
   int               wcnt;
   logic [2:0]       served [$];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [62:0] put(input int i, input logic [20:0] a);
      logic [62:0] v;
      v = '0;
      v[i*21 +: 21] = a;
      return v;
   endfunction

   task automatic model_clear();
      m_pend = '0;
      m_ptr = 0;
      m_out = -1;
      m_ldata = '0;
      m_lv = '0;
      m_hit = '0;
      wcnt = 0;
      for (int i = 0; i < 3; i++) begin
         m_addr[i] = '0;
         m_la[i] = '0;
         m_ld[i] = '0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      l_req = '0;
      sdr_rdy = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
      chk("rst_sdr_req", 64'(sdr_req), 64'(1'b0));
      chk("rst_sdr_addr", 64'(sdr_addr), 64'(25'h0));
      chk("rst_l_rdy", 64'(l_rdy), 64'(3'b000));
      chk("rst_l_data", 64'(l_data), 64'(32'h0));
   endtask

   task automatic tick(input logic [2:0] req, input logic [62:0] addr,
                       input logic rdy, input logic [31:0] data);
      logic [2:0] exp_rdy;
      int g;
      l_req = req;
      l_addr = addr;
      sdr_rdy = rdy;
      sdr_data = data;
      @(posedge clk);
      exp_rdy = '0;
      if (m_out >= 0) begin
         if (rdy) begin
            exp_rdy[m_out] = 1'b1;
            m_ldata = data;
            m_lv[m_out] = 1'b1;
            m_la[m_out] = m_out_la;
            m_ld[m_out] = data;
            m_out = -1;
         end
      end else if (m_pend != '0) begin
         g = m_ptr;
         while (!m_pend[g]) g = (g + 1) % 3;
         m_out = g;
         m_out_la = m_addr[g];
         m_pend[g] = 1'b0;
         m_ptr = (g + 1) % 3;
      end
`ifdef ROM_ARB_LAST_HIT_EN
      if (exp_rdy == '0 && m_hit != '0) begin
         g = m_hit[0] ? 0 : (m_hit[1] ? 1 : 2);
         exp_rdy[g] = 1'b1;
         m_ldata = m_ld[g];
         m_hit[g] = 1'b0;
      end
`endif
      for (int i = 0; i < 3; i++) begin
         if (req[i]) begin
`ifdef ROM_ARB_LAST_HIT_EN
            if (m_lv[i] && addr[i*21 +: 21] == m_la[i]) begin
               m_hit[i] = 1'b1;
               continue;
            end
`endif
            m_pend[i] = 1'b1;
            m_addr[i] = addr[i*21 +: 21];
         end
      end
      #1;
      l_req = '0;
      sdr_rdy = 1'b0;
      if (l_rdy != '0) served.push_back(l_rdy);
      chk("l_rdy", 64'(l_rdy), 64'(exp_rdy));
      chk("l_data", 64'(l_data), 64'(m_ldata));
      chk("sdr_req", 64'(sdr_req), 64'(m_out >= 0));
      if (m_out >= 0)
         chk("sdr_addr", 64'(sdr_addr), 64'(BASE + {4'b0, m_out_la}));
   endtask

   // SDRAM answers lat cycles after the grant; optional random stale pulses.
   task automatic run(input int n, input int lat, input int pct);
      logic [2:0]  req;
      logic [62:0] a;
      logic        rdy;
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < 3; i++) begin
            req[i] = ($urandom_range(99) < pct);
            a[i*21 +: 21] = 21'($urandom);
         end
         if (m_out >= 0) rdy = (wcnt >= lat);
         else rdy = (pct > 0) && ($urandom_range(7) == 0);
         tick(req, a, rdy, $urandom);
         wcnt = (m_out >= 0) ? wcnt + 1 : 0;
      end
   endtask

   initial begin
      l_req = '0;
      l_addr = '0;
      sdr_rdy = 1'b0;
      sdr_data = '0;
      model_clear();

      // Single request through ROM_BASE offset
      do_reset();
      tick(3'b001, put(0, 21'h012345), 1'b0, 32'h0);
      tick(3'b000, '0, 1'b0, 32'h0);
      chk("t1_req", 64'(sdr_req), 64'(1'b1));
      chk("t1_addr", 64'(sdr_addr), 64'(25'h112345));
      tick(3'b000, '0, 1'b0, 32'h0);
      tick(3'b000, '0, 1'b1, 32'hDEADBEEF);
      chk("t1_rdy", 64'(l_rdy), 64'(3'b001));
      chk("t1_data", 64'(l_data), 64'(32'hDEADBEEF));
      tick(3'b000, '0, 1'b0, 32'h0);
      chk("t1_rdy_off", 64'(l_rdy), 64'(3'b000));

      // All three at once, latency 4
      do_reset();
      served.delete();
      tick(3'b111, {21'h3, 21'h2, 21'h1}, 1'b0, 32'h0);
      run(40, 4, 0);
      chk("t2_cnt", 64'(served.size()), 64'd3);
      if (served.size() == 3) begin
         chk("t2_o0", 64'(served[0]), 64'(3'b001));
         chk("t2_o1", 64'(served[1]), 64'(3'b010));
         chk("t2_o2", 64'(served[2]), 64'(3'b100));
      end

      // Newest address wins while waiting
      do_reset();
      served.delete();
      tick(3'b001, put(0, 21'h55), 1'b0, 32'h0);
      tick(3'b000, '0, 1'b0, 32'h0);
      tick(3'b010, put(1, 21'h10), 1'b0, 32'h0);
      tick(3'b010, put(1, 21'h20), 1'b0, 32'h0);
      wcnt = 3;
      run(20, 2, 0);
      chk("t3_cnt", 64'(served.size()), 64'd2);
      if (served.size() == 2)
         chk("t3_l1", 64'(served[1]), 64'(3'b010));

      // Reset during BUSY, late response ignored
      do_reset();
      tick(3'b100, put(2, 21'h77), 1'b0, 32'h0);
      tick(3'b000, '0, 1'b0, 32'h0);
      chk("t4_busy", 64'(sdr_req), 64'(1'b1));
      do_reset();
      tick(3'b000, '0, 1'b0, 32'h0);
      tick(3'b000, '0, 1'b1, 32'hCAFEF00D);
      tick(3'b000, '0, 1'b0, 32'h0);
      chk("t4_idle", 64'(sdr_req), 64'(1'b0));

      // Re-request on the completion edge
      do_reset();
      tick(3'b100, put(2, 21'h0AA), 1'b0, 32'h0);
      tick(3'b000, '0, 1'b0, 32'h0);
      tick(3'b100, put(2, 21'h0BB), 1'b1, 32'h12345678);
      chk("t5_rdy", 64'(l_rdy), 64'(3'b100));
      chk("t5_data", 64'(l_data), 64'(32'h12345678));
      tick(3'b000, '0, 1'b0, 32'h0);
      tick(3'b000, '0, 1'b0, 32'h0);
      chk("t5_req2", 64'(sdr_req), 64'(1'b1));
      chk("t5_addr2", 64'(sdr_addr), 64'(25'h1000BB));
      wcnt = 1;
      run(5, 1, 0);

`ifdef ROM_ARB_LAST_HIT_EN
      do_reset();
      tick(3'b001, put(0, 21'h400), 1'b0, 32'h0);
      tick(3'b000, '0, 1'b0, 32'h0);
      tick(3'b000, '0, 1'b1, 32'hA5A5A5A5);
      tick(3'b001, put(0, 21'h400), 1'b0, 32'h0);
      tick(3'b000, '0, 1'b0, 32'h0);
      chk("t6_rdy", 64'(l_rdy), 64'(3'b001));
      chk("t6_data", 64'(l_data), 64'(32'hA5A5A5A5));
      chk("t6_nosdr", 64'(sdr_req), 64'(1'b0));
`endif

      // Random traffic with varied latency and stale responses
      do_reset();
      for (int r = 0; r < 6; r++) run(80, $urandom_range(5), 25 + 10 * r);
      run(30, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
